// File: rtl/field_deconcatenator_if.sv
// Bundle of the serial input link and the parallel field output of the deconcatenator.
// The slave modport is the deconcatenator's view; the master modport is its environment's view.
interface field_deconcatenator_if #(
  parameter int A_W = 1,
  parameter int B_W = 3,
  parameter int C_W = 4
);
  logic           sin;
  logic           sin_valid;
  logic           sin_sync;
  logic [A_W-1:0] a_out;
  logic [B_W-1:0] b_out;
  logic [C_W-1:0] c_out;
  logic           out_valid;
  logic           out_ready;
  logic           overflow;
  logic           ovf_clr;

  modport slave (
    input  sin, sin_valid, sin_sync, out_ready, ovf_clr,
    output a_out, b_out, c_out, out_valid, overflow
  );

  modport master (
    output sin, sin_valid, sin_sync, out_ready, ovf_clr,
    input  a_out, b_out, c_out, out_valid, overflow
  );
endinterface

// File: rtl/field_deconcatenator.sv
// Serial-to-parallel splitter: collects an MSB-first {a, b, c} frame one bit per valid
// cycle and presents the fields through a one-entry holding register with sticky overflow.
module field_deconcatenator #(
  parameter int A_W = 1,
  parameter int B_W = 3,
  parameter int C_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  field_deconcatenator_if.slave   bus
);
  localparam int FW    = A_W + B_W + C_W;
  localparam int CNT_W = $clog2(FW + 1);

  typedef enum logic {HUNT, ASSEMBLE} state_t;

  state_t          r_state;
  logic [CNT_W-1:0] r_count;
  logic [FW-1:0]   r_shift;
  logic [A_W-1:0]  r_a;
  logic [B_W-1:0]  r_b;
  logic [C_W-1:0]  r_c;
  logic            r_valid;
  logic            r_ovf;

  logic             w_sync;
  logic             w_take;
  logic [FW-1:0]    w_shift_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_done;
  logic             w_load;
  logic             w_drop;

  // A sync bit always restarts at bit 0, so any partial frame is flushed from the shifter.
  assign w_sync       = bus.sin_valid && bus.sin_sync;
  assign w_take       = bus.sin_valid && ((r_state == ASSEMBLE) || w_sync);
  assign w_shift_next = w_sync ? {{(FW-1){1'b0}}, bus.sin} : {r_shift[FW-2:0], bus.sin};
  assign w_count_next = w_sync ? CNT_W'(1) : r_count + 1'b1;
  assign w_done       = w_take && (w_count_next == CNT_W'(FW));
  assign w_load       = w_done && (!r_valid || bus.out_ready);
  assign w_drop       = w_done && !w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_count <= '0;
      r_shift <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_take) begin
        r_state <= ASSEMBLE;
        r_shift <= w_shift_next;
        r_count <= w_done ? '0 : w_count_next;
      end

      // Drain and reload in the same cycle keeps full throughput with out_ready held high.
      if (w_load) begin
        r_a     <= w_shift_next[FW-1 -: A_W];
        r_b     <= w_shift_next[C_W +: B_W];
        r_c     <= w_shift_next[C_W-1:0];
        r_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.a_out     = r_a;
  assign bus.b_out     = r_b;
  assign bus.c_out     = r_c;
  assign bus.out_valid = r_valid;
  assign bus.overflow  = r_ovf;
endmodule
